// File: rtl/qspi_flash_rd_seq_if.sv
// Register-mapped req/rsp port between the flash read sequencer and the qspi register wrapper.
interface qspi_flash_rd_seq_if;
  logic       req_vld;
  logic       req_rdy;
  logic [2:0] req_addr;
  logic       req_read;
  logic [7:0] req_dat;
  logic       rsp_vld;
  logic       rsp_rdy;
  logic [7:0] rsp_dat;

  modport master (
    output req_vld, req_addr, req_read, req_dat, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_dat
  );

  modport slave (
    input  req_vld, req_addr, req_read, req_dat, rsp_rdy,
    output req_rdy, rsp_vld, rsp_dat
  );
endinterface

// File: rtl/qspi_flash_rd_seq.sv
// Flash read sequencer: turns one (address, length) read command into the qspi register
// write/read sequence and streams the returned bytes out on a valid/ready port.
module qspi_flash_rd_seq #(
  parameter logic [7:0]  CMD_RD      = 8'h03,
  parameter logic [1:0]  SPI_MODE    = 2'b00,
  parameter logic [3:0]  SPI_DIV     = 4'd2,
  parameter int unsigned DUMMY_BYTES = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_req_vld,
  output logic                       rd_req_rdy,
  input  logic [23:0]                rd_req_addr,
  input  logic [7:0]                 rd_req_len,
  output logic                       rd_dat_vld,
  input  logic                       rd_dat_rdy,
  output logic [7:0]                 rd_dat,
  output logic                       rd_dat_last,
  output logic                       busy,
  qspi_flash_rd_seq_if.master        qspi_if
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG0, S_CS_LO, S_CMD, S_ADDR, S_DUMMY, S_READ, S_CS_HI
  } state_t;

  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_BYTES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_wait_rsp;
  logic [3:0]  r_idx;
  logic [8:0]  r_remain;
  logic [23:0] r_addr;
  logic        w_accept;
  logic        w_req_fire;
  logic        w_rsp_take;

  assign w_accept   = (r_state == S_IDLE) && rd_req_vld;
  assign w_req_fire = qspi_if.req_vld && qspi_if.req_rdy;
  // During READ the consumer's ready is the only thing that completes a response.
  assign w_rsp_take = r_wait_rsp && qspi_if.rsp_vld &&
                      ((r_state == S_READ) ? rd_dat_rdy : 1'b1);
  assign rd_dat     = qspi_if.rsp_dat;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_state_nxt      = r_state;
    rd_req_rdy       = 1'b0;
    busy             = 1'b1;
    rd_dat_vld       = 1'b0;
    rd_dat_last      = 1'b0;
    qspi_if.req_vld  = (r_state != S_IDLE) && !r_wait_rsp;
    qspi_if.req_addr = 3'b000;
    qspi_if.req_read = 1'b0;
    qspi_if.req_dat  = 8'h00;
    qspi_if.rsp_rdy  = (r_state != S_IDLE) && r_wait_rsp;

    case (r_state)
      S_IDLE: begin
        rd_req_rdy = 1'b1;
        busy       = 1'b0;
        if (rd_req_vld) w_state_nxt = S_CFG0;
      end
      S_CFG0: begin
        qspi_if.req_dat = {SPI_MODE, 1'b0, 2'b00, 1'b0, 2'b00};
        if (w_rsp_take) w_state_nxt = S_CS_LO;
      end
      S_CS_LO: begin
        qspi_if.req_addr = 3'b001;
        qspi_if.req_dat  = {SPI_DIV, 1'b0, 3'b000};
        if (w_rsp_take) w_state_nxt = S_CMD;
      end
      S_CMD: begin
        qspi_if.req_addr = 3'b010;
        qspi_if.req_dat  = CMD_RD;
        if (w_rsp_take) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        qspi_if.req_addr = 3'b010;
        case (r_idx)
          4'd0:    qspi_if.req_dat = r_addr[23:16];
          4'd1:    qspi_if.req_dat = r_addr[15:8];
          default: qspi_if.req_dat = r_addr[7:0];
        endcase
        if (w_rsp_take && r_idx == 4'd2)
          w_state_nxt = (DUMMY_BYTES == 0) ? S_READ : S_DUMMY;
      end
      S_DUMMY: begin
        qspi_if.req_addr = 3'b010;
        if (w_rsp_take && r_idx == DUMMY_LAST) w_state_nxt = S_READ;
      end
      S_READ: begin
        qspi_if.req_addr = 3'b010;
        qspi_if.req_read = 1'b1;
        qspi_if.rsp_rdy  = r_wait_rsp && rd_dat_rdy;
        rd_dat_vld       = r_wait_rsp && qspi_if.rsp_vld;
        rd_dat_last      = r_wait_rsp && qspi_if.rsp_vld && (r_remain == 9'd1);
        if (w_rsp_take && r_remain == 9'd1) w_state_nxt = S_CS_HI;
      end
      S_CS_HI: begin
        qspi_if.req_addr = 3'b001;
        qspi_if.req_dat  = {SPI_DIV, 1'b1, 3'b000};
        if (w_rsp_take) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_rsp <= 1'b0;
      r_idx      <= 4'd0;
      r_remain   <= 9'd0;
      r_addr     <= 24'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr   <= rd_req_addr;
        r_remain <= (rd_req_len == 8'h00) ? 9'd256 : {1'b0, rd_req_len};
      end
      if (w_req_fire)      r_wait_rsp <= 1'b1;
      else if (w_rsp_take) r_wait_rsp <= 1'b0;
      if (w_rsp_take) begin
        if (r_state == S_ADDR || r_state == S_DUMMY)
          r_idx <= (w_state_nxt == r_state) ? r_idx + 4'd1 : 4'd0;
        if (r_state == S_READ)
          r_remain <= r_remain - 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_qspi_flash_rd_seq.sv
// Bench for qspi_flash_rd_seq: two instances (0 and 2 dummy bytes) against a flash-like slave model.
module tb_qspi_flash_rd_seq;

  localparam logic [7:0] CMD_RD  = 8'h03;
  localparam logic [3:0] SPI_DIV = 4'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req_vld = 1'b0;
  logic [23:0] rd_req_addr = 24'd0;
  logic [7:0]  rd_req_len = 8'd0;
  logic        rd_dat_rdy = 1'b0;
  logic [1:0]  rd_req_rdy, rd_dat_vld, rd_dat_last, busy;
  logic [7:0]  rd_dat [2];

  always #5 clk = ~clk;

  qspi_flash_rd_seq_if u_if0 ();
  qspi_flash_rd_seq_if u_if1 ();

  qspi_flash_rd_seq #(.CMD_RD(CMD_RD), .SPI_MODE(2'b00), .SPI_DIV(SPI_DIV), .DUMMY_BYTES(0)) dut0 (
    .clk(clk), .rst(rst), .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy[0]),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len), .rd_dat_vld(rd_dat_vld[0]),
    .rd_dat_rdy(rd_dat_rdy), .rd_dat(rd_dat[0]), .rd_dat_last(rd_dat_last[0]),
    .busy(busy[0]), .qspi_if(u_if0.master)
  );

  qspi_flash_rd_seq #(.CMD_RD(CMD_RD), .SPI_MODE(2'b00), .SPI_DIV(SPI_DIV), .DUMMY_BYTES(2)) dut1 (
    .clk(clk), .rst(rst), .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy[1]),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len), .rd_dat_vld(rd_dat_vld[1]),
    .rd_dat_rdy(rd_dat_rdy), .rd_dat(rd_dat[1]), .rd_dat_last(rd_dat_last[1]),
    .busy(busy[1]), .qspi_if(u_if1.master)
  );

  // Flat views of both instances' qspi ports so procedural loops can index them.
  logic [1:0] m_req_vld, m_req_read, m_rsp_rdy;
  logic [2:0] m_req_addr [2];
  logic [7:0] m_req_dat [2];
  logic [1:0] s_req_rdy = 2'b00;
  logic [1:0] s_rsp_vld = 2'b00;
  logic [7:0] s_rsp_dat [2] = '{8'h00, 8'h00};

  assign m_req_vld[0] = u_if0.req_vld;   assign m_req_vld[1] = u_if1.req_vld;
  assign m_req_read[0] = u_if0.req_read; assign m_req_read[1] = u_if1.req_read;
  assign m_rsp_rdy[0] = u_if0.rsp_rdy;   assign m_rsp_rdy[1] = u_if1.rsp_rdy;
  assign m_req_addr[0] = u_if0.req_addr; assign m_req_addr[1] = u_if1.req_addr;
  assign m_req_dat[0] = u_if0.req_dat;   assign m_req_dat[1] = u_if1.req_dat;
  assign u_if0.req_rdy = s_req_rdy[0];   assign u_if1.req_rdy = s_req_rdy[1];
  assign u_if0.rsp_vld = s_rsp_vld[0];   assign u_if1.rsp_vld = s_rsp_vld[1];
  assign u_if0.rsp_dat = s_rsp_dat[0];   assign u_if1.rsp_dat = s_rsp_dat[1];

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Flash contents as a pure function of byte address.
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    return (a[7:0] ^ 8'h5A) + a[15:8] + ~a[23:16];
  endfunction

  // Slave model state, one slot per instance.
  bit          pend [2];
  bit          pend_rd [2];
  int          dly [2];
  logic [7:0]  pend_dat [2];
  int          bcnt [2];
  int          rcnt [2];
  logic [23:0] faddr [2];
  int          stall_left [2];
  bit          stall_seen [2];
  bit          stall_now [2];
  logic [11:0] req_log [2][$];
  logic [8:0]  dat_log [2][$];
  int          bp_mode = 0;
  bit          bp_tog = 1'b0;

  // Drive on the falling edge, evaluate handshakes 1 ns later, well before the rising edge.
  always begin
    @(negedge clk);
    case (bp_mode)
      0:       rd_dat_rdy = 1'b1;
      1:       rd_dat_rdy = 1'($urandom_range(0, 1));
      default: begin bp_tog = !bp_tog; rd_dat_rdy = bp_tog; end
    endcase
    for (int i = 0; i < 2; i++) begin
      s_rsp_vld[i] = !rst && pend[i] && dly[i] == 0;
      s_rsp_dat[i] = pend_dat[i];
      stall_now[i] = !rst && stall_left[i] > 0 &&
                     (stall_seen[i] || (m_req_vld[i] && m_req_addr[i] == 3'b010 &&
                                        !m_req_read[i] && bcnt[i] == 0));
      s_req_rdy[i] = !rst && !stall_now[i] && ($urandom_range(0, 3) != 0);
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        pend[i] = 1'b0; bcnt[i] = 0; rcnt[i] = 0; stall_seen[i] = 1'b0;
      end else begin
        if (stall_now[i]) begin
          check("stall_vld", 32'(m_req_vld[i]), 32'd1);
          check("stall_dat", 32'(m_req_dat[i]), 32'(CMD_RD));
          stall_seen[i] = 1'b1;
          stall_left[i]--;
        end
        if (m_req_vld[i]) check("one_outstanding", 32'(pend[i]), 32'd0);
        if (s_rsp_vld[i]) begin
          if (pend_rd[i]) begin
            check("dat_vld", 32'(rd_dat_vld[i]), 32'd1);
            check("rsp_rdy_mirror", 32'(m_rsp_rdy[i]), 32'(rd_dat_rdy));
            check("dat_pass", 32'(rd_dat[i]), 32'(pend_dat[i]));
          end else begin
            check("dat_vld_wr", 32'(rd_dat_vld[i]), 32'd0);
            check("rsp_rdy_wr", 32'(m_rsp_rdy[i]), 32'd1);
          end
          if (m_rsp_rdy[i]) begin
            pend[i] = 1'b0;
            if (pend_rd[i]) dat_log[i].push_back({rd_dat_last[i], rd_dat[i]});
          end
        end else if (pend[i] && dly[i] > 0) begin
          dly[i]--;
        end
        if (m_req_vld[i] && s_req_rdy[i]) begin
          req_log[i].push_back({m_req_read[i], m_req_addr[i], m_req_read[i] ? 8'h00 : m_req_dat[i]});
          pend[i]    = 1'b1;
          pend_rd[i] = m_req_read[i];
          dly[i]     = $urandom_range(0, 2);
          if (m_req_read[i]) begin
            pend_dat[i] = fbyte(faddr[i] + 24'(rcnt[i]));
            rcnt[i]++;
          end else begin
            pend_dat[i] = 8'($urandom);
            if (m_req_addr[i] == 3'b001 && !m_req_dat[i][3]) begin
              bcnt[i] = 0;
              rcnt[i] = 0;
            end else if (m_req_addr[i] == 3'b010) begin
              if (bcnt[i] >= 1 && bcnt[i] <= 3) faddr[i] = {faddr[i][15:0], m_req_dat[i]};
              bcnt[i]++;
            end
          end
        end
      end
    end
  end

  task automatic start_cmd(input logic [23:0] addr, input logic [7:0] len);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      req_log[i].delete();
      dat_log[i].delete();
      check("req_rdy_idle", 32'(rd_req_rdy[i]), 32'd1);
    end
    rd_req_vld  = 1'b1;
    rd_req_addr = addr;
    rd_req_len  = len;
    @(negedge clk);
    rd_req_vld  = 1'b0;
    rd_req_addr = 24'($urandom);
    rd_req_len  = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      check("busy_after_accept", 32'(busy[i]), 32'd1);
      check("req_rdy_busy", 32'(rd_req_rdy[i]), 32'd0);
    end
  endtask

  task automatic wait_done();
    for (int c = 0; c < 12000; c++) begin
      @(negedge clk);
      if (busy == 2'b00) return;
    end
    check("done_timeout", 32'(busy), 32'd0);
  endtask

  task automatic compare(input logic [23:0] addr, input logic [7:0] len);
    int n = (len == 8'h00) ? 256 : int'(len);
    for (int i = 0; i < 2; i++) begin
      logic [11:0] exp_req [$];
      logic [8:0]  exp_dat [$];
      exp_req.push_back({1'b0, 3'd0, 8'h00});
      exp_req.push_back({1'b0, 3'd1, SPI_DIV, 4'h0});
      exp_req.push_back({1'b0, 3'd2, CMD_RD});
      exp_req.push_back({1'b0, 3'd2, addr[23:16]});
      exp_req.push_back({1'b0, 3'd2, addr[15:8]});
      exp_req.push_back({1'b0, 3'd2, addr[7:0]});
      for (int d = 0; d < 2 * i; d++) exp_req.push_back({1'b0, 3'd2, 8'h00});
      for (int k = 0; k < n; k++) begin
        exp_req.push_back({1'b1, 3'd2, 8'h00});
        exp_dat.push_back({k == n - 1, fbyte(addr + 24'(k))});
      end
      exp_req.push_back({1'b0, 3'd1, SPI_DIV, 4'h8});
      check("req_count", 32'(req_log[i].size()), 32'(exp_req.size()));
      for (int k = 0; k < exp_req.size() && k < req_log[i].size(); k++)
        check("req_entry", 32'(req_log[i][k]), 32'(exp_req[k]));
      check("dat_count", 32'(dat_log[i].size()), 32'(exp_dat.size()));
      for (int k = 0; k < exp_dat.size() && k < dat_log[i].size(); k++)
        check("dat_entry", 32'(dat_log[i][k]), 32'(exp_dat[k]));
      check("req_rdy_end", 32'(rd_req_rdy[i]), 32'd1);
    end
  endtask

  task automatic run(input logic [23:0] addr, input logic [7:0] len);
    start_cmd(addr, len);
    wait_done();
    compare(addr, len);
  endtask

  initial begin
    logic [23:0] a;
    logic [7:0]  l;
    stall_left = '{0, 0};
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_req_rdy", 32'(rd_req_rdy[i]), 32'd1);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_req_vld", 32'(m_req_vld[i]), 32'd0);
      check("rst_dat_vld", 32'(rd_dat_vld[i]), 32'd0);
      check("rst_dat_last", 32'(rd_dat_last[i]), 32'd0);
      check("rst_req_bus", {20'd0, m_req_read[i], m_req_addr[i], m_req_dat[i]}, 32'd0);
    end
    rst = 1'b0;

    bp_mode = 0;
    run(24'h123456, 8'd1);

    bp_mode = 1;
    a = 24'($urandom);
    run(a, 8'h00);

    bp_mode = 0;
    stall_left = '{5, 5};
    a = 24'($urandom);
    run(a, 8'd3);
    for (int i = 0; i < 2; i++) check("stall_applied", 32'(stall_left[i]), 32'd0);

    bp_mode = 2;
    a = 24'($urandom);
    run(a, 8'd4);

    bp_mode = 1;
    a = 24'($urandom);
    start_cmd(a, 8'd6);
    for (int c = 0; c < 2000 && req_log[0].size() < 4; c++) @(negedge clk);
    check("reach_addr", 32'(req_log[0].size() >= 4), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("abort_busy", 32'(busy[i]), 32'd0);
      check("abort_req_rdy", 32'(rd_req_rdy[i]), 32'd1);
      check("abort_req_vld", 32'(m_req_vld[i]), 32'd0);
    end
    a = 24'($urandom);
    l = 8'($urandom_range(1, 10));
    run(a, l);

    for (int t = 0; t < 5; t++) begin
      bp_mode = $urandom_range(0, 2);
      a = 24'($urandom);
      l = 8'($urandom_range(0, 12));
      run(a, l);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
